missile_slot_scheduler: RTL and testbench

//   Shares the pool of player_projectile slots between fire requests. Edge-detects shoot, grants
//   a free slot round-robin, enforces a frame-based cooldown, and tracks in-flight slots until

---
 rtl/missile_slot_scheduler_pkg.sv | 16 +
 rtl/missile_slot_scheduler_if.sv | 26 ++
 rtl/missile_slot_scheduler_frame_tick_sync.sv | 27 ++
 rtl/missile_slot_scheduler.sv | 148 ++++++++++++++
 tb/tb_missile_slot_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/missile_slot_scheduler_pkg.sv
// Shared types and constants for the missile slot scheduler.
package missile_slot_scheduler_pkg;

    // Number of player projectile instances in the game.
    localparam int NUM_MISSILES = 3;

    // Width of the frame cooldown counter (cooldown range is 1..15 frames).
    localparam int COOL_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/missile_slot_scheduler_if.sv
// Bundle between the fire-request side (keyboard/game logic) and the scheduler.
interface missile_slot_scheduler_if #(
    parameter int NUM_SLOTS = 3,
    parameter int CNT_W     = 16
);
    logic                 game_active;
    logic                 shoot;
    logic [NUM_SLOTS-1:0] slot_done;
    logic [NUM_SLOTS-1:0] fire;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic                 cooldown;
    logic [CNT_W-1:0]     shots_fired;
    logic [CNT_W-1:0]     shots_dropped;

    // Requesting side: drives the key, game state and slot completions.
    modport master (
        output game_active, shoot, slot_done,
        input  fire, slot_busy, cooldown, shots_fired, shots_dropped
    );

    // Scheduler side.
    modport slave (
        input  game_active, shoot, slot_done,
        output fire, slot_busy, cooldown, shots_fired, shots_dropped
    );
endinterface

// File: rtl/missile_slot_scheduler_frame_tick_sync.sv
// Brings the vertical-sync frame clock into the Clk domain and turns each
// rising edge into a single-cycle tick (three Clk cycles after the edge).
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);
    logic sync1_reg, sync2_reg, sync3_reg, tick_reg;

    // Two-flop synchronizer, one history flop, and a registered edge pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            sync1_reg <= frame_clk;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            tick_reg  <= sync2_reg & ~sync3_reg;
        end
    end

    assign frame_tick = tick_reg;
endmodule

// File: rtl/missile_slot_scheduler.sv
// Arbitrates projectile slots between shoot key presses: edge-detects the key,
// grants a free slot round-robin, enforces a frame-counted cooldown and tracks
// which slots are still in flight.
module missile_slot_scheduler
    import missile_slot_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS       = NUM_MISSILES,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int CNT_W           = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    missile_slot_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    sched_state_t         state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]     chosen_reg, chosen_next;
    logic [COOL_W-1:0]    cool_cnt_reg, cool_cnt_next;
    logic [NUM_SLOTS-1:0] busy_reg, busy_next, launch_set;
    logic [CNT_W-1:0]     fired_reg, fired_next;
    logic [CNT_W-1:0]     dropped_reg, dropped_next;
    logic                 shoot_q_reg;
    logic                 shoot_edge, frame_tick, pick_free;
    logic [IDX_W-1:0]     pick_idx;

    // First free slot searching ptr+1, ptr+2, ... with wrap; MSB flags success.
    // Scanning from the farthest candidate inward lets the nearest one win.
    function automatic logic [IDX_W:0] pick_slot(input logic [NUM_SLOTS-1:0] busy,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W:0] result;
        logic [IDX_W:0] sum;
        result = '0;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_SLOTS)) sum = sum - SUM_W'(NUM_SLOTS);
            if (!busy[sum[IDX_W-1:0]]) result = {1'b1, sum[IDX_W-1:0]};
        end
        return result;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    frame_tick_sync u_frame_tick_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign shoot_edge = bus.shoot & ~shoot_q_reg;
    assign {pick_free, pick_idx} = pick_slot(busy_reg, rr_ptr_reg);

    // State, pointers, counters and the key history register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= IDX_W'(NUM_SLOTS - 1);
            chosen_reg   <= '0;
            cool_cnt_reg <= '0;
            busy_reg     <= '0;
            fired_reg    <= '0;
            dropped_reg  <= '0;
            shoot_q_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            chosen_reg   <= chosen_next;
            cool_cnt_reg <= cool_cnt_next;
            busy_reg     <= busy_next;
            fired_reg    <= fired_next;
            dropped_reg  <= dropped_next;
            shoot_q_reg  <= bus.shoot;
        end
    end

    // Next-state logic: grant, launch, cooldown countdown and abort on game stop.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        chosen_next   = chosen_reg;
        cool_cnt_next = cool_cnt_reg;
        fired_next    = fired_reg;
        dropped_next  = dropped_reg;
        launch_set    = '0;
        case (state_reg)
            IDLE: begin
                if (shoot_edge) begin
                    if (pick_free) begin
                        state_next  = FIRE;
                        chosen_next = pick_idx;
                    end else begin
                        dropped_next = sat_inc(dropped_reg);
                    end
                end
            end
            FIRE: begin
                launch_set[chosen_reg] = 1'b1;
                rr_ptr_next   = chosen_reg;
                fired_next    = sat_inc(fired_reg);
                cool_cnt_next = COOL_INIT;
                state_next    = COOLDOWN;
            end
            COOLDOWN: begin
                if (shoot_edge) dropped_next = sat_inc(dropped_reg);
                if (frame_tick) begin
                    if (cool_cnt_reg <= COOL_W'(1)) begin
                        cool_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        cool_cnt_next = cool_cnt_reg - COOL_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A stopped game cancels everything except the pointer and the statistics.
        if (!bus.game_active) begin
            state_next    = IDLE;
            launch_set    = '0;
            cool_cnt_next = '0;
            rr_ptr_next   = rr_ptr_reg;
            fired_next    = fired_reg;
            dropped_next  = dropped_reg;
        end
    end

    // Per-slot occupancy: a fresh launch beats a same-cycle completion.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_busy
            assign busy_next[gi] = bus.game_active &
                                   (launch_set[gi] | (busy_reg[gi] & ~bus.slot_done[gi]));
        end
    endgenerate

    assign bus.fire          = launch_set;
    assign bus.slot_busy     = busy_reg;
    assign bus.cooldown      = (state_reg == COOLDOWN);
    assign bus.shots_fired   = fired_reg;
    assign bus.shots_dropped = dropped_reg;
endmodule

// File: tb/tb_missile_slot_scheduler.sv
// Directed bench for missile_slot_scheduler with a cycle model of the slot
// pool checked every cycle plus hand-computed expectations per scenario.
module tb_missile_slot_scheduler;
    localparam int N    = 3;
    localparam int COOL = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_clk;
    int   checks = 0;
    int   failures = 0;

    missile_slot_scheduler_if #(.NUM_SLOTS(N), .CNT_W(CW)) bus();

    missile_slot_scheduler #(
        .NUM_SLOTS       (N),
        .COOLDOWN_FRAMES (COOL),
        .CNT_W           (CW)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [N-1:0] m_busy;
    int         m_ptr, m_chosen, m_cool, m_fired, m_dropped;
    bit         m_pending, m_shoot_prev;
    bit [3:0]   m_fc;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_busy = '0; m_ptr = N - 1; m_chosen = 0; m_cool = 0;
        m_fired = 0; m_dropped = 0; m_pending = 0; m_shoot_prev = 0; m_fc = '0;
    endtask

    task automatic model_step();
        bit         tick_now, edge_now;
        bit [N-1:0] done;
        int         pick;
        // frame_clk rising edge reaches the scheduler three clocks later
        tick_now = m_fc[2] & ~m_fc[3];
        m_fc = {m_fc[2:0], frame_clk};
        edge_now = bus.shoot & ~m_shoot_prev;
        m_shoot_prev = bus.shoot;
        done = bus.slot_done;
        if (!bus.game_active) begin
            m_busy = '0; m_pending = 0; m_cool = 0;
        end else if (m_pending) begin
            m_busy = (m_busy & ~done) | (N'(1) << m_chosen);
            m_ptr = m_chosen; m_fired = sat(m_fired); m_cool = COOL; m_pending = 0;
        end else if (m_cool > 0) begin
            if (edge_now) m_dropped = sat(m_dropped);
            m_busy = m_busy & ~done;
            if (tick_now) m_cool--;
        end else begin
            if (edge_now) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && !m_busy[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                if (pick >= 0) begin
                    m_pending = 1; m_chosen = pick;
                end else begin
                    m_dropped = sat(m_dropped);
                end
            end
            m_busy = m_busy & ~done;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        int exp_fire;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_fire", int'(bus.fire), 0);
                check("rst_busy", int'(bus.slot_busy), 0);
                check("rst_cooldown", int'(bus.cooldown), 0);
                check("rst_fired", int'(bus.shots_fired), 0);
                check("rst_dropped", int'(bus.shots_dropped), 0);
            end else begin
                exp_fire = (m_pending && bus.game_active) ? (1 << m_chosen) : 0;
                check("cyc_fire", int'(bus.fire), exp_fire);
                check("cyc_busy", int'(bus.slot_busy), int'(m_busy));
                check("cyc_cooldown", int'(bus.cooldown), (m_cool > 0) ? 1 : 0);
                check("cyc_fired", int'(bus.shots_fired), m_fired);
                check("cyc_dropped", int'(bus.shots_dropped), m_dropped);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; step();
        frame_clk = 1'b0; step(); step(); step();
    endtask

    task automatic cool_out();
        repeat (COOL) frame_pulse();
        step();
    endtask

    task automatic press(output int f);
        bus.shoot = 1'b1; step();
        f = int'(bus.fire);
        bus.shoot = 1'b0; step();
        $display("press: fire=%03b busy=%03b fired=%0d dropped=%0d",
                 f[2:0], bus.slot_busy, bus.shots_fired, bus.shots_dropped);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, nfires;
        rst_n = 1'b1; frame_clk = 1'b0;
        bus.game_active = 1'b0; bus.shoot = 1'b0; bus.slot_done = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fire", int'(bus.fire), 0);
        check("reset_busy", int'(bus.slot_busy), 0);
        check("reset_fired", int'(bus.shots_fired), 0);
        rst_n = 1'b1; bus.game_active = 1'b1;

        // first grant goes to slot 0, one cycle after the edge
        repeat (10) step();
        bus.shoot = 1'b1; step();
        check("first_fire", int'(bus.fire), 1);
        step();
        check("first_busy", int'(bus.slot_busy), 1);
        check("first_fired", int'(bus.shots_fired), 1);
        check("first_cooldown", int'(bus.cooldown), 1);

        // key held: no further launches; eight frames end the cooldown
        nfires = 0;
        for (int i = 0; i < 200; i++) begin
            frame_clk = (i < 32) && (i % 4 == 0);
            step();
            if (bus.fire != '0) nfires++;
        end
        check("hold_extra_fires", nfires, 0);
        check("hold_cooldown_end", int'(bus.cooldown), 0);
        bus.shoot = 1'b0; step();

        // round robin 010, 100, then all busy -> dropped
        press(f); check("rr_second", f, 2); cool_out();
        press(f); check("rr_third", f, 4); cool_out();
        check("all_busy", int'(bus.slot_busy), 7);
        press(f); check("full_no_fire", f, 0);
        check("full_dropped", int'(bus.shots_dropped), 1);
        check("full_no_cooldown", int'(bus.cooldown), 0);
        bus.slot_done = 3'b010; step(); bus.slot_done = '0;
        check("done_clears", int'(bus.slot_busy), 5);
        press(f); check("refill_slot1", f, 2);

        // edge during frame 3 of 8 is rejected
        repeat (3) frame_pulse();
        press(f); check("cool_no_fire", f, 0);
        check("cool_dropped", int'(bus.shots_dropped), 2);
        check("cool_still_high", int'(bus.cooldown), 1);
        repeat (5) frame_pulse();
        step();
        check("cool_done", int'(bus.cooldown), 0);

        // release and edge in the same cycle: release not yet visible
        bus.shoot = 1'b1; bus.slot_done = 3'b001; step();
        check("same_cycle_no_fire", int'(bus.fire), 0);
        bus.slot_done = '0; bus.shoot = 1'b0;
        check("same_cycle_dropped", int'(bus.shots_dropped), 3);
        check("same_cycle_busy", int'(bus.slot_busy), 6);
        step();
        bus.shoot = 1'b1; step();
        check("next_cycle_fire", int'(bus.fire), 1);
        bus.shoot = 1'b0; step();

        // game stop clears busy, ignores edges, keeps pointer
        bus.slot_done = 3'b100; step(); bus.slot_done = '0;
        check("busy_011", int'(bus.slot_busy), 3);
        bus.game_active = 1'b0; step();
        check("abort_busy", int'(bus.slot_busy), 0);
        check("abort_cooldown", int'(bus.cooldown), 0);
        press(f); check("inactive_no_fire", f, 0);
        check("inactive_not_dropped", int'(bus.shots_dropped), 3);
        bus.game_active = 1'b1; step();
        press(f); check("ptr_held", f, 2);

        // dropped counter saturates at all-ones
        repeat (14) press(f);
        check("dropped_saturate", int'(bus.shots_dropped), CMAX);
        cool_out();

        // asynchronous reset in the middle of a launch
        bus.shoot = 1'b1; step();
        check("pre_reset_fire", int'(bus.fire), 4);
        #1 rst_n = 1'b0;
        #1;
        check("async_fire", int'(bus.fire), 0);
        check("async_fired", int'(bus.shots_fired), 0);
        check("async_dropped", int'(bus.shots_dropped), 0);
        check("async_busy", int'(bus.slot_busy), 0);
        bus.shoot = 1'b0; step();
        rst_n = 1'b1; step();
        press(f); check("post_reset_slot0", f, 1);
        check("post_reset_fired", int'(bus.shots_fired), 1);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
